keynsham_dbus_decoder: RTL and testbench
========================================

Name: keynsham_dbus_decoder

Overview:
Data-bus address decoder and response mux between the CPU data port and the bootrom, RAM and IO slaves. Decodes each CPU data access to one slave and drives that slave's chip-select with a single-cycle access strobe. Returns the slave's registered read data and ack to the CPU. Unmapped addresses and slaves that fail to ack within TIMEOUT cycles complete with a bus error, so the CPU never hangs.

Parameters:
ROM_BASE, 32'h0000_0000, byte base of bootrom region
ROM_WORDS, 128, bootrom size in 32-bit words
RAM_BASE, 32'h2000_0000, byte base of RAM region
RAM_WORDS, 8192, RAM size in words
IO_BASE, 32'h8000_0000, byte base of IO region
IO_WORDS, 4096, IO size in words
TIMEOUT, 255, maximum WAIT cycles before error (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_addr  in  30  CPU word address (byte address [31:2])
cpu_access  in  1  CPU request; held high until cpu_ack or cpu_error
cpu_wr_en  in  1  1 = write, 0 = read
cpu_bytesel  in  4  byte lanes
cpu_wr_val  in  32  write data
cpu_data  out  32  registered read data
cpu_ack  out  1  one-cycle completion pulse
cpu_error  out  1  one-cycle bus-error pulse
s_addr  out  30  word offset within the selected region: (cpu_addr - base/4)
s_access  out  1  one-cycle access strobe to slaves
s_wr_en  out  1  pass-through of cpu_wr_en
s_bytesel  out  4  pass-through of cpu_bytesel
s_wr_val  out  32  pass-through of cpu_wr_val
rom_cs, ram_cs, io_cs  out  1 each  slave chip-selects
rom_data, ram_data, io_data  in  32 each  slave read data
rom_ack, ram_ack, io_ack  in  1 each  slave acks

Behaviour:
- Reset (async, rst_n low): state IDLE. cpu_data=0, cpu_ack=0, cpu_error=0, s_access=0, all cs=0, latched select cleared, timeout counter=0.
- Region hit test: base/4 <= cpu_addr < base/4 + WORDS. At most one region may hit; regions must not overlap (parameter misconfiguration is not checked).
- The s_addr, s_wr_en, s_bytesel and s_wr_val outputs are combinational from the CPU inputs.
- IDLE:
  - cpu_access=0: stay in IDLE.
  - cpu_access=1 with a region hit: in the same cycle assert s_access=1 and the matching cs combinationally. Latch the select, load counter=TIMEOUT, go to WAIT.
  - cpu_access=1 with no hit: no cs, no s_access; go to ERR.
- WAIT:
  - The latched cs stays high and s_access=0.
  - Latched slave ack=1: register its data into cpu_data and go to DONE.
  - Otherwise, counter=1 at this edge: go to ERR. Otherwise decrement the counter.
  - Acks and data from non-selected slaves are ignored.
- DONE: cpu_ack=1 for exactly this cycle, cs cleared, return to IDLE.
- ERR: cpu_error=1 for exactly this cycle, cpu_data=0, cs cleared, return to IDLE.
- cpu_access is ignored outside IDLE. The CPU drops cpu_access in the cycle it samples cpu_ack/cpu_error, so no request is re-issued.
- cpu_data holds its last value except in ERR, where it is cleared to 0.
- Latency:
  - Bootrom (acks one cycle after strobe): access accepted at edge 0, rom_ack high in cycle 1, cpu_ack in cycle 2. Three cycles from request to ack.
  - Unmapped address: cpu_error in cycle 1.
  - Silent slave: cpu_error after TIMEOUT+1 cycles.
- Writes to the ROM region are forwarded unchanged; the ROM acks and ignores them, so a write to ROM completes with cpu_ack, not cpu_error.
- rst_n asserted in WAIT/DONE/ERR aborts immediately with no ack or error; a late slave ack after reset is ignored in IDLE.

Test Plan:
- Read word 5 of ROM (cpu_addr=30'h5), slave returns 32'hDEADBEEF one cycle later -> rom_cs=1 and s_access=1 in cycle 0, s_addr=5, cpu_ack=1 with cpu_data=32'hDEADBEEF in cycle 2, a single pulse.
- Read at byte address 32'h4000_0000 (unmapped) -> no cs, no s_access, cpu_error=1 in cycle 1, cpu_data=0.
- RAM read at 32'h2000_0010 with TIMEOUT=4 and ram_ack held low -> s_addr=4, cpu_error at cycle 5, ram_cs drops after.
- IO write at 32'h8000_0008, bytesel=4'b0011, io_ack after 3 cycles, with io_ack and ram_ack toggled spuriously meanwhile -> only io_ack completes the access, s_bytesel=4'b0011 and s_wr_val passed through, exactly one cpu_ack.
- Back-to-back ROM reads at words 0 and 127 -> two separate acks with the correct data; word 128 (byte 32'h200) -> cpu_error.
- rst_n pulsed low mid-WAIT, then a late rom_ack -> all outputs 0, state IDLE, no cpu_ack generated.

Source files
------------

// File: rtl/keynsham_dbus_decoder.sv
// Data-bus decoder between the CPU data port and the bootrom, RAM and IO
// slaves. Each access is routed to one slave with a one-cycle strobe. The
// slave's ack and read data are registered back to the CPU. An unmapped
// address, or a slave that never acks, ends with a one-cycle bus error.
module keynsham_dbus_decoder #(
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int          ROM_WORDS = 128,
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter int          RAM_WORDS = 8192,
    parameter logic [31:0] IO_BASE   = 32'h8000_0000,
    parameter int          IO_WORDS  = 4096,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] cpu_addr,
    input  logic        cpu_access,
    input  logic        cpu_wr_en,
    input  logic [3:0]  cpu_bytesel,
    input  logic [31:0] cpu_wr_val,
    output logic [31:0] cpu_data,
    output logic        cpu_ack,
    output logic        cpu_error,
    output logic [29:0] s_addr,
    output logic        s_access,
    output logic        s_wr_en,
    output logic [3:0]  s_bytesel,
    output logic [31:0] s_wr_val,
    output logic        rom_cs,
    output logic        ram_cs,
    output logic        io_cs,
    input  logic [31:0] rom_data,
    input  logic [31:0] ram_data,
    input  logic [31:0] io_data,
    input  logic        rom_ack,
    input  logic        ram_ack,
    input  logic        io_ack
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    localparam logic [30:0] ROM_LO = {1'b0, ROM_BASE[31:2]};
    localparam logic [30:0] RAM_LO = {1'b0, RAM_BASE[31:2]};
    localparam logic [30:0] IO_LO  = {1'b0, IO_BASE[31:2]};
    localparam logic [15:0] TO_LD  = 16'(TIMEOUT);

    state_t      state;
    logic [2:0]  sel_q;     // {io, ram, rom}, held while waiting for the ack
    logic [15:0] cnt;
    logic [30:0] rom_off, ram_off, io_off;
    logic [2:0]  hit;
    logic        take;
    logic [2:0]  acks;

    // Offset into each region. An address below the base wraps to at least
    // 2^30, which is above any legal region size, so one compare is a full
    // range test.
    always_comb begin
        rom_off = {1'b0, cpu_addr} - ROM_LO;
        ram_off = {1'b0, cpu_addr} - RAM_LO;
        io_off  = {1'b0, cpu_addr} - IO_LO;
        hit[0]  = rom_off < 31'(ROM_WORDS);
        hit[1]  = ram_off < 31'(RAM_WORDS);
        hit[2]  = io_off  < 31'(IO_WORDS);
    end

    // Slave-side request fields come straight from the CPU inputs.
    always_comb begin
        s_wr_en   = cpu_wr_en;
        s_bytesel = cpu_bytesel;
        s_wr_val  = cpu_wr_val;
        if (hit[0])      s_addr = rom_off[29:0];
        else if (hit[1]) s_addr = ram_off[29:0];
        else if (hit[2]) s_addr = io_off[29:0];
        else             s_addr = cpu_addr;
    end

    // Strobe and chip-selects: decoded live on acceptance, latched in WAIT.
    always_comb begin
        take     = (state == IDLE) && cpu_access;
        s_access = take && (|hit);
        rom_cs   = take ? hit[0] : sel_q[0];
        ram_cs   = take ? hit[1] : sel_q[1];
        io_cs    = take ? hit[2] : sel_q[2];
        acks     = {io_ack, ram_ack, rom_ack} & sel_q;
    end

    // Access sequencer; ack/error are single-cycle registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= 3'b000;
            cnt       <= 16'd0;
            cpu_data  <= 32'd0;
            cpu_ack   <= 1'b0;
            cpu_error <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            cpu_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_access) begin
                        if (|hit) begin
                            sel_q <= hit;
                            cnt   <= TO_LD;
                            state <= WAIT;
                        end else begin
                            cpu_error <= 1'b1;
                            cpu_data  <= 32'd0;
                            state     <= ERR;
                        end
                    end
                end
                WAIT: begin
                    if (|acks) begin
                        if (sel_q[0])      cpu_data <= rom_data;
                        else if (sel_q[1]) cpu_data <= ram_data;
                        else               cpu_data <= io_data;
                        cpu_ack <= 1'b1;
                        sel_q   <= 3'b000;
                        state   <= DONE;
                    end else if (cnt == 16'd1) begin
                        cpu_error <= 1'b1;
                        cpu_data  <= 32'd0;
                        sel_q     <= 3'b000;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keynsham_dbus_decoder.sv
// Directed bench for keynsham_dbus_decoder. Each request pushes its expected
// completion (kind, data, cycle) into a queue; a monitor pops and checks it
// whenever the decoder raises cpu_ack or cpu_error.
module tb_keynsham_dbus_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] cpu_addr = '0;
    logic        cpu_access = 1'b0;
    logic        cpu_wr_en = 1'b0;
    logic [3:0]  cpu_bytesel = '0;
    logic [31:0] cpu_wr_val = '0;
    logic [31:0] cpu_data;
    logic        cpu_ack, cpu_error;
    logic [29:0] s_addr;
    logic        s_access, s_wr_en;
    logic [3:0]  s_bytesel;
    logic [31:0] s_wr_val;
    logic        rom_cs, ram_cs, io_cs;
    logic [31:0] rom_data = '0, ram_data = '0, io_data = '0;
    logic        rom_ack = 1'b0, ram_ack = 1'b0, io_ack = 1'b0;

    keynsham_dbus_decoder #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_access(cpu_access), .cpu_wr_en(cpu_wr_en),
        .cpu_bytesel(cpu_bytesel), .cpu_wr_val(cpu_wr_val),
        .cpu_data(cpu_data), .cpu_ack(cpu_ack), .cpu_error(cpu_error),
        .s_addr(s_addr), .s_access(s_access), .s_wr_en(s_wr_en),
        .s_bytesel(s_bytesel), .s_wr_val(s_wr_val),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .io_cs(io_cs),
        .rom_data(rom_data), .ram_data(ram_data), .io_data(io_data),
        .rom_ack(rom_ack), .ram_ack(ram_ack), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (cpu_ack || cpu_error) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: ack=%b err=%b data=%h with nothing outstanding (cycle %0d)",
                         cpu_ack, cpu_error, cpu_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_kind", {30'd0, cpu_error, cpu_ack}, {30'd0, e.err, ~e.err});
                chk("resp_data", cpu_data, e.data);
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One complete access. ack_src: 0 rom, 1 ram, 2 io, 3 none. The chosen
    // slave acks in cycle ack_cyc; the response is expected in cycle lat.
    task automatic access(input logic [29:0] addr, input logic wr, input logic [3:0] bsel,
                          input logic [31:0] wval, input logic [2:0] exp_cs,
                          input logic [29:0] exp_saddr, input int ack_src, input int ack_cyc,
                          input logic [31:0] ack_data, input bit spur, input logic exp_err,
                          input logic [31:0] exp_data, input int lat);
        exp_t e;
        cpu_addr = addr; cpu_wr_en = wr; cpu_bytesel = bsel; cpu_wr_val = wval;
        cpu_access = 1'b1;
        e.err = exp_err; e.data = exp_data; e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        chk("c0_cs", {29'd0, io_cs, ram_cs, rom_cs}, {29'd0, exp_cs});
        chk("c0_s_access", {31'd0, s_access}, {31'd0, |exp_cs});
        if (|exp_cs) begin
            chk("c0_s_addr", {2'b0, s_addr}, {2'b0, exp_saddr});
            chk("c0_s_wr_en", {31'd0, s_wr_en}, {31'd0, wr});
            chk("c0_s_bytesel", {28'd0, s_bytesel}, {28'd0, bsel});
            chk("c0_s_wr_val", s_wr_val, wval);
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            rom_ack = (ack_src == 0 && k == ack_cyc);
            ram_ack = (ack_src == 1 && k == ack_cyc);
            io_ack  = (ack_src == 2 && k == ack_cyc);
            rom_data = (ack_src == 0) ? ack_data : 32'h0BAD_0000;
            ram_data = (ack_src == 1) ? ack_data : 32'h0BAD_0001;
            io_data  = (ack_src == 2) ? ack_data : 32'h0BAD_0002;
            if (spur && k < ack_cyc) begin
                if (ack_src != 0) rom_ack = k[0];
                if (ack_src != 1) ram_ack = ~k[0];
                if (ack_src != 2) io_ack  = k[0];
            end
            @(negedge clk);
            if (k < lat) begin
                chk("wait_cs", {29'd0, io_cs, ram_cs, rom_cs}, {29'd0, exp_cs});
                chk("wait_s_access", {31'd0, s_access}, 32'd0);
            end else begin
                chk("resp_cs_clear", {29'd0, io_cs, ram_cs, rom_cs}, 32'd0);
            end
        end
        @(posedge clk); #1;
        rom_ack = 0; ram_ack = 0; io_ack = 0;
        cpu_access = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_ack_err", {30'd0, cpu_ack, cpu_error}, 32'd0);
        chk("rst_s_access_cs", {28'd0, s_access, io_cs, ram_cs, rom_cs}, 32'd0);
        @(posedge clk); #1;

        // ROM read word 5
        access(30'h5, 0, 4'hF, 32'h0, 3'b001, 30'h5, 0, 1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 2);
        // Unmapped byte address 0x4000_0000
        access(30'h1000_0000, 0, 4'hF, 32'h0, 3'b000, 30'h0, 3, 0, 32'h0, 0, 1, 32'h0, 1);
        // Silent RAM at byte 0x2000_0010, TIMEOUT=4
        access(30'h0800_0004, 0, 4'hF, 32'h0, 3'b010, 30'h4, 3, 0, 32'h0, 0, 1, 32'h0, 5);
        // IO write at byte 0x8000_0008, acks in cycle 3 amid spurious acks
        access(30'h2000_0002, 1, 4'b0011, 32'hCAFE_F00D, 3'b100, 30'h2, 2, 3, 32'h1234_5678, 1, 0,
               32'h1234_5678, 4);
        // Back-to-back ROM reads at first and last word, then one past the end
        access(30'h0, 0, 4'hF, 32'h0, 3'b001, 30'h0, 0, 1, 32'h0000_0011, 0, 0, 32'h0000_0011, 2);
        access(30'h7F, 0, 4'hF, 32'h0, 3'b001, 30'h7F, 0, 1, 32'h7F7F_7F7F, 0, 0, 32'h7F7F_7F7F, 2);
        access(30'h80, 0, 4'hF, 32'h0, 3'b000, 30'h0, 3, 0, 32'h0, 0, 1, 32'h0, 1);
        // Write to ROM is acked, not errored
        access(30'h3, 1, 4'hF, 32'h5555_AAAA, 3'b001, 30'h3, 0, 1, 32'hA5A5_0003, 0, 0, 32'hA5A5_0003, 2);

        // Reset in the middle of WAIT, then a late ROM ack
        cpu_addr = 30'h5; cpu_wr_en = 0; cpu_access = 1'b1;
        @(posedge clk); #1;
        cpu_access = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {cpu_data[0], 26'd0, cpu_ack, cpu_error, s_access, rom_cs, ram_cs},
            32'd0);
        chk("abort_data", cpu_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rom_ack = 1'b1; rom_data = 32'hFEED_FACE;
        @(posedge clk); #1;
        rom_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_idle", {27'd0, cpu_ack, cpu_error, s_access, rom_cs, io_cs}, 32'd0);
            chk("late_ack_data", cpu_data, 32'd0);
        end

        repeat (2) @(posedge clk);
        chk("outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
